// File: rtl/wb_cache_pkg.sv
// ---------------------------------------------------------------------------
// wb_cache_pkg
// Shared types and helpers for the write-back data cache controller.
//   state_t          controller FSM states
//   calc_offset_len  log2(words per line)
//   calc_tag_len     tag width left over after index and offset
//   merge_word       byte-enable merge of a store word into an existing word.
//                    Operates on MERGE_W-bit containers so any DATA_LEN up to
//                    MERGE_W can use it; callers size-cast in and out.
// ---------------------------------------------------------------------------
package wb_cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WB        = 3'd2,
    FILL      = 3'd3,
    FILL_WAIT = 3'd4,
    RESP      = 3'd5
  } state_t;

  localparam int MERGE_W = 256;

  function automatic int calc_offset_len(input int line_size, input int data_len);
    return $clog2(line_size / data_len);
  endfunction

  function automatic int calc_tag_len(input int addr_len, input int index_len,
                                      input int offset_len);
    return addr_len - index_len - offset_len;
  endfunction

  function automatic logic [MERGE_W-1:0] merge_word(input logic [MERGE_W-1:0]   old_w,
                                                    input logic [MERGE_W-1:0]   new_w,
                                                    input logic [MERGE_W/8-1:0] strb);
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int b = 0; b < MERGE_W / 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_cache_ram.sv
// ---------------------------------------------------------------------------
// wb_cache_ram
// Single-port block RAM holding one {tag,line} entry per cache index.
// One-cycle read latency; the read register only updates on a read, so the
// last entry read stays visible while the controller writes elsewhere.
// Contents are not reset.
//   clk    clock
//   en     access enable
//   we     1 = write full entry, 0 = read
//   addr   entry index
//   wdata  entry to write
//   rdata  entry read on the previous enabled read
// ---------------------------------------------------------------------------
module wb_cache_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 143
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_cache_ctrl.sv
// ---------------------------------------------------------------------------
// wb_cache_ctrl
// Direct-mapped, write-back, write-allocate data cache controller between the
// core load/store unit and the DRAM line FIFO.
//
// Handshakes: a transfer happens on a rising edge where valid && ready. Once
// raised, a valid is held with all payload fields stable until that edge.
// mem_rsp_valid has no ready; fill data is taken in the cycle it is valid.
//
// Ports
//   clk, rstn                    clock, synchronous active-low reset
//   cpu_req_valid/ready          core request handshake (ready only in IDLE)
//   cpu_req_we/addr/wdata/wstrb  store flag, word address, store data, byte enables
//   cpu_rsp_valid                one-cycle completion pulse (loads and stores)
//   cpu_rsp_rdata                load data, held until the next load completes
//   mem_req_valid/ready          line request handshake
//   mem_req_we/addr/wdata        1 = write-back / 0 = fill, line address, line
//   mem_rsp_valid/rdata          fill line return
//   dbg_state                    current FSM state (wb_cache_pkg::state_t)
//   hit_cnt/miss_cnt/wb_cnt      saturating statistics, only with WB_CACHE_STATS_EN
//
// Optional macro: WB_CACHE_STATS_EN adds the three statistics counters.
// ---------------------------------------------------------------------------
module wb_cache_ctrl
  import wb_cache_pkg::*;
#(
  parameter int DATA_LEN   = 32,
  parameter int LINE_SIZE  = 128,
  parameter int ADDR_LEN   = 27,
  parameter int INDEX_LEN  = 10
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic                                        cpu_req_valid,
  output logic                                        cpu_req_ready,
  input  logic                                        cpu_req_we,
  input  logic [ADDR_LEN-1:0]                         cpu_req_addr,
  input  logic [DATA_LEN-1:0]                         cpu_req_wdata,
  input  logic [DATA_LEN/8-1:0]                       cpu_req_wstrb,
  output logic                                        cpu_rsp_valid,
  output logic [DATA_LEN-1:0]                         cpu_rsp_rdata,
  output logic                                        mem_req_valid,
  input  logic                                        mem_req_ready,
  output logic                                        mem_req_we,
  output logic [ADDR_LEN-calc_offset_len(LINE_SIZE, DATA_LEN)-1:0] mem_req_addr,
  output logic [LINE_SIZE-1:0]                        mem_req_wdata,
  input  logic                                        mem_rsp_valid,
  input  logic [LINE_SIZE-1:0]                        mem_rsp_rdata,
  output logic [2:0]                                  dbg_state
`ifdef WB_CACHE_STATS_EN
  ,
  output logic [31:0]                                 hit_cnt,
  output logic [31:0]                                 miss_cnt,
  output logic [31:0]                                 wb_cnt
`endif
);

  localparam int OFFSET_LEN = calc_offset_len(LINE_SIZE, DATA_LEN);
  localparam int TAG_LEN    = calc_tag_len(ADDR_LEN, INDEX_LEN, OFFSET_LEN);
  localparam int STRB_LEN   = DATA_LEN / 8;
  localparam int NUM_LINES  = 2**INDEX_LEN;
  localparam int ENTRY_LEN  = TAG_LEN + LINE_SIZE;

  state_t                 state;
  logic                   req_we;
  logic [ADDR_LEN-1:0]    req_addr;
  logic [DATA_LEN-1:0]    req_wdata;
  logic [STRB_LEN-1:0]    req_wstrb;
  logic [NUM_LINES-1:0]   valid_q;
  logic [NUM_LINES-1:0]   dirty_q;

  logic [TAG_LEN-1:0]     req_tag;
  logic [INDEX_LEN-1:0]   req_idx;
  logic [OFFSET_LEN-1:0]  req_off;

  logic                   ram_en;
  logic                   ram_we;
  logic [INDEX_LEN-1:0]   ram_addr;
  logic [ENTRY_LEN-1:0]   ram_wdata;
  logic [ENTRY_LEN-1:0]   ram_rdata;
  logic [TAG_LEN-1:0]     ram_tag;
  logic [LINE_SIZE-1:0]   ram_line;

  logic                   accept;
  logic                   hit;
  logic [LINE_SIZE-1:0]   base_line;
  logic [DATA_LEN-1:0]    base_word;
  logic [LINE_SIZE-1:0]   merged_line;

  assign req_tag   = req_addr[ADDR_LEN-1 -: TAG_LEN];
  assign req_idx   = req_addr[OFFSET_LEN +: INDEX_LEN];
  assign req_off   = req_addr[OFFSET_LEN-1:0];
  assign ram_tag   = ram_rdata[ENTRY_LEN-1 -: TAG_LEN];
  assign ram_line  = ram_rdata[LINE_SIZE-1:0];
  assign accept    = cpu_req_valid && cpu_req_ready;
  assign hit       = valid_q[req_idx] && (ram_tag == req_tag);
  assign dbg_state = state;

  // The line being worked on is the RAM entry during LOOKUP and the incoming
  // fill line during FILL_WAIT; the store merge is applied to either.
  always_comb begin
    base_line   = (state == FILL_WAIT) ? mem_rsp_rdata : ram_line;
    base_word   = base_line[int'(req_off)*DATA_LEN +: DATA_LEN];
    merged_line = base_line;
    merged_line[int'(req_off)*DATA_LEN +: DATA_LEN] =
      DATA_LEN'(merge_word(MERGE_W'(base_word), MERGE_W'(req_wdata),
                           (MERGE_W/8)'(req_wstrb)));
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = req_idx;
    ram_wdata = {req_tag, merged_line};
    case (state)
      IDLE: begin
        if (accept) begin
          ram_en   = 1'b1;
          ram_addr = cpu_req_addr[OFFSET_LEN +: INDEX_LEN];
        end
      end
      LOOKUP: begin
        if (hit && req_we) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
        end
      end
      FILL_WAIT: begin
        if (mem_rsp_valid) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_wdata = {req_tag, (req_we ? merged_line : base_line)};
        end
      end
      default: ;
    endcase
  end

  wb_cache_ram #(
    .ADDR_W (INDEX_LEN),
    .DATA_W (ENTRY_LEN)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      cpu_req_ready <= 1'b0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_rdata <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      valid_q       <= '0;
      dirty_q       <= '0;
      req_we        <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      req_wstrb     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_we        <= cpu_req_we;
            req_addr      <= cpu_req_addr;
            req_wdata     <= cpu_req_wdata;
            req_wstrb     <= cpu_req_wstrb;
            cpu_req_ready <= 1'b0;
            state         <= LOOKUP;
          end else begin
            cpu_req_ready <= 1'b1;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_we) dirty_q[req_idx] <= 1'b1;
            else        cpu_rsp_rdata    <= base_word;
            cpu_rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b1;
            mem_req_addr  <= {ram_tag, req_idx};
            mem_req_wdata <= ram_line;
            state         <= WB;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= {req_tag, req_idx};
            state         <= FILL;
          end
        end
        WB: begin
          // The fill request follows back-to-back; valid stays high.
          if (mem_req_ready) begin
            mem_req_we   <= 1'b0;
            mem_req_addr <= {req_tag, req_idx};
            state        <= FILL;
          end
        end
        FILL: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (mem_rsp_valid) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= req_we;
            if (!req_we) cpu_rsp_rdata <= base_word;
            cpu_rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          cpu_rsp_valid <= 1'b0;
          cpu_req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (state == LOOKUP && hit && hit_cnt != 32'hFFFF_FFFF)
        hit_cnt <= hit_cnt + 32'd1;
      if (state == LOOKUP && !hit && miss_cnt != 32'hFFFF_FFFF)
        miss_cnt <= miss_cnt + 32'd1;
      if (state == WB && mem_req_ready && wb_cnt != 32'hFFFF_FFFF)
        wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_cache_ctrl
// Self-checking bench for wb_cache_ctrl. A flat word-addressed memory model
// gives the value every load must return; a per-index tag/valid/dirty table
// predicts hits, write-backs and fills; a line-addressed DRAM model answers
// fills and absorbs write-backs.
// ---------------------------------------------------------------------------
module tb_wb_cache_ctrl;
  import wb_cache_pkg::*;

  logic         clk;
  logic         rstn;
  logic         cpu_req_valid;
  logic         cpu_req_ready;
  logic         cpu_req_we;
  logic [26:0]  cpu_req_addr;
  logic [31:0]  cpu_req_wdata;
  logic [3:0]   cpu_req_wstrb;
  logic         cpu_rsp_valid;
  logic [31:0]  cpu_rsp_rdata;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_we;
  logic [24:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_rdata;
  logic [2:0]   dbg_state;
`ifdef WB_CACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
  logic [31:0]  wb_cnt;
`endif

  wb_cache_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_we    (cpu_req_we),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_req_wstrb (cpu_req_wstrb),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_rdata (cpu_rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .dbg_state     (dbg_state)
`ifdef WB_CACHE_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .wb_cnt        (wb_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int unsigned check_cnt;
  int unsigned pass_cnt;
  int unsigned fail_cnt;

  // expected line requests: {we, line_addr[24:0], wdata[127:0]}
  logic [153:0] exp_q[$];

  logic [31:0]  ref_w [logic [26:0]];   // words stored by the core
  logic [127:0] dram  [logic [24:0]];   // lines held by memory
  logic         mv [1024];
  logic         md [1024];
  logic [14:0]  mt [1024];

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] init_word(input logic [26:0] a);
    return ({5'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [127:0] dram_line(input logic [24:0] la);
    logic [127:0] l;
    if (dram.exists(la)) return dram[la];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = init_word({la, 2'(w)});
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [26:0] a);
    logic [127:0] l;
    if (ref_w.exists(a)) return ref_w[a];
    l = dram_line(a[26:2]);
    return l[a[1:0]*32 +: 32];
  endfunction

  function automatic logic [127:0] ref_line(input logic [24:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = ref_word({la, 2'(w)});
    return l;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 1024; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = '0;
    end
    // Dirty data that was never written back is lost by the reset.
    ref_w.delete();
    exp_q.delete();
  endfunction

  // ---------------- driver: one core access, memory side answered inline ----------------
  // Called and returning on a falling edge.
  task automatic run_access(input logic we, input logic [26:0] addr,
                            input logic [31:0] wd, input logic [3:0] ws,
                            input int stall_n);
    logic [9:0]   idx;
    logic [14:0]  tag;
    logic         exp_hit;
    logic         exp_wb;
    logic [31:0]  exp_rd;
    logic [153:0] front;
    logic [24:0]  fill_la;
    int           n;
    int           guard;
    int           stall_left;
    int           fill_dly;
    bit           fill_pend;
    bit           done;

    idx     = addr[11:2];
    tag     = addr[26:12];
    exp_hit = mv[idx] && (mt[idx] == tag);
    exp_wb  = !exp_hit && mv[idx] && md[idx];
    if (exp_wb)   exp_q.push_back({1'b1, mt[idx], idx, ref_line({mt[idx], idx})});
    if (!exp_hit) exp_q.push_back({1'b0, tag, idx, 128'h0});
    exp_rd = ref_word(addr);
    if (we) ref_w[addr] = byte_merge(exp_rd, wd, ws);
    md[idx] = exp_hit ? (md[idx] | we) : we;
    mv[idx] = 1'b1;
    mt[idx] = tag;

    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wd;
    cpu_req_wstrb = ws;
    guard = 0;
    while (!cpu_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("req_accepted", 128'(cpu_req_ready), 128'd1);
    @(negedge clk);
    cpu_req_valid = 1'b0;

    n          = 1;
    stall_left = stall_n;
    fill_pend  = 0;
    fill_dly   = 0;
    fill_la    = '0;
    done       = 0;
    while (!done && n < 300) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (fill_pend) begin
        if (fill_dly == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = dram_line(fill_la);
          fill_pend     = 0;
        end else fill_dly--;
      end
      if (mem_req_valid) begin
        check_eq("ready_while_busy", 128'(cpu_req_ready), 128'd0);
        check_eq("memreq_expected", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
          front = exp_q[0];
          check_eq("memreq_we", 128'(mem_req_we), 128'(front[153]));
          check_eq("memreq_addr", 128'(mem_req_addr), 128'(front[152:128]));
          if (front[153]) check_eq("memreq_wdata", mem_req_wdata, front[127:0]);
          if (stall_left > 0) stall_left--;
          else if ($urandom_range(0, 2) != 0) begin
            mem_req_ready = 1'b1;
            void'(exp_q.pop_front());
            if (front[153]) dram[front[152:128]] = mem_req_wdata;
            else begin
              fill_pend = 1;
              fill_dly  = $urandom_range(0, 3);
              fill_la   = front[152:128];
            end
          end
        end
      end
      if (cpu_rsp_valid) begin
        check_eq("memreq_all_done", 128'(exp_q.size()), 128'd0);
        if (!we) check_eq("load_rdata", 128'(cpu_rsp_rdata), 128'(exp_rd));
        if (exp_hit) check_eq("hit_latency", 128'(n), 128'd2);
        done = 1;
      end
      @(negedge clk);
      n++;
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    check_eq("rsp_seen", 128'(done), 128'd1);
    check_eq("rsp_single_pulse", 128'(cpu_rsp_valid), 128'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    check_cnt = 0;
    pass_cnt  = 0;
    fail_cnt  = 0;
    rstn          = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    cpu_req_wstrb = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    model_reset();
    dram[25'h4] = 128'h44443333_22221111_00000000_DEADBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 128'(cpu_req_ready), 128'd0);
    check_eq("rst_rsp_valid", 128'(cpu_rsp_valid), 128'd0);
    check_eq("rst_rsp_rdata", 128'(cpu_rsp_rdata), 128'd0);
    check_eq("rst_mem_valid", 128'(mem_req_valid), 128'd0);
    check_eq("rst_mem_we", 128'(mem_req_we), 128'd0);
    check_eq("rst_mem_addr", 128'(mem_req_addr), 128'd0);
    check_eq("rst_mem_wdata", mem_req_wdata, 128'd0);
    check_eq("rst_state", 128'(dbg_state), 128'(IDLE));
    rstn = 1'b1;
    @(negedge clk);

    // Directed: cold miss, hit, store hit, load back, dirty eviction with stall.
    run_access(1'b0, 27'h0000013, 32'h0, 4'h0, 0);
    run_access(1'b0, 27'h0000013, 32'h0, 4'h0, 0);
    run_access(1'b1, 27'h0000011, 32'hAABBCCDD, 4'b0011, 0);
    run_access(1'b0, 27'h0000011, 32'h0, 4'h0, 0);
    check_eq("merged_word", 128'(ref_word(27'h0000011)), 128'h0000CCDD);
    run_access(1'b0, 27'h0001011, 32'h0, 4'h0, 5);
    check_eq("wb_line_in_dram", dram[25'h4], 128'h44443333_22221111_0000CCDD_DEADBEEF);
`ifdef WB_CACHE_STATS_EN
    check_eq("hit_cnt", 128'(hit_cnt), 128'd3);
    check_eq("miss_cnt", 128'(miss_cnt), 128'd2);
    check_eq("wb_cnt", 128'(wb_cnt), 128'd1);
`endif

    // Reset while waiting for fill data; the late response must be ignored.
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 27'h0002013;
    guard = 0;
    while (!cpu_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    cpu_req_valid = 1'b0;
    guard = 0;
    while (!mem_req_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("rstfw_fill_req", 128'(mem_req_valid), 128'd1);
    check_eq("rstfw_fill_addr", 128'(mem_req_addr), 128'h804);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check_eq("rstfw_state", 128'(dbg_state), 128'(FILL_WAIT));
    rstn = 1'b0;
    @(negedge clk);
    check_eq("rstfw_mem_valid", 128'(mem_req_valid), 128'd0);
    check_eq("rstfw_req_ready", 128'(cpu_req_ready), 128'd0);
    rstn          = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = dram_line(25'h804);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("rstfw_no_rsp", 128'(cpu_rsp_valid), 128'd0);
      check_eq("rstfw_no_memreq", 128'(mem_req_valid), 128'd0);
      @(negedge clk);
    end
    model_reset();
    run_access(1'b0, 27'h0002013, 32'h0, 4'h0, 0);
    run_access(1'b0, 27'h0000013, 32'h0, 4'h0, 0);

    // Random mix on a few indices and tags to force conflicts and evictions.
    for (int k = 0; k < 150; k++) begin
      logic [26:0] a;
      a = {13'(0), 2'($urandom_range(0, 3)), 7'(0), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3))};
      run_access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
